// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: operand/result bundle for the float-to-fixed converter.
// The master drives the float operand and load strobe; the slave returns the scaled integer.
interface float_to_fixed_if #(
    parameter int EXP_W = 8,
    parameter int INT_W = 32
);
    logic [31:0]      float_in;
    logic             load_new;
    logic [INT_W-1:0] fixed_out;
    logic [EXP_W-1:0] exp_out;
    logic             busy;
    logic             done;
    logic             invalid;

    modport master (
        output float_in, load_new,
        input  fixed_out, exp_out, busy, done, invalid
    );

    modport slave (
        input  float_in, load_new,
        output fixed_out, exp_out, busy, done, invalid
    );
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: multi-cycle IEEE-754 single to minimal odd integer times 2^exp, one trailing zero per clock.
// Define FLOAT_TO_FIXED_SUBNORMAL_EN to decode subnormals; otherwise they flush to zero.
module float_to_fixed #(
    parameter int EXP_W = 8,
    parameter int INT_W = 32
) (
    input logic             clk,
    input logic             reset_n,
    float_to_fixed_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UNPACK, STRIP, FINISH} state_t;

    localparam int E_MIN = -(2 ** (EXP_W - 1));

    state_t             state_q, state_d;
    logic [31:0]        in_q, in_d;
    logic [23:0]        mag_q, mag_d;
    logic signed [9:0]  e_q, e_d;
    logic               s_q, s_d;
    logic               err_q, err_d;
    logic [INT_W-1:0]   fixed_q, fixed_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               done_q, done_d;
    logic               invalid_q, invalid_d;
    logic [INT_W-1:0]   mag_ext;

    assign mag_ext = {{(INT_W - 24){1'b0}}, mag_q};

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        mag_d     = mag_q;
        e_d       = e_q;
        s_d       = s_q;
        err_d     = err_q;
        fixed_d   = fixed_q;
        exp_d     = exp_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_new) begin
                    in_d    = bus.float_in;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                s_d   = in_q[31];
                err_d = &in_q[30:23];
                mag_d = {1'b1, in_q[22:0]};
                e_d   = $signed({2'b00, in_q[30:23]}) - 10'sd150;
                if (in_q[30:23] == 8'd0) begin
`ifdef FLOAT_TO_FIXED_SUBNORMAL_EN
                    mag_d = {1'b0, in_q[22:0]};
                    // a zero fraction must not trip the underflow check
                    e_d   = (in_q[22:0] == '0) ? 10'sd0 : -10'sd149;
`else
                    mag_d = '0;
                    e_d   = '0;
`endif
                end
                state_d = err_d ? FINISH : STRIP;
            end
            STRIP: begin
                if (mag_q == '0 || mag_q[0]) begin
                    state_d = FINISH;
                end else begin
                    mag_d = mag_q >> 1;
                    e_d   = e_q + 10'sd1;
                end
            end
            FINISH: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                invalid_d = err_q || (int'(e_q) < E_MIN);
                fixed_d   = (invalid_d || mag_q == '0) ? '0 : (s_q ? -mag_ext : mag_ext);
                exp_d     = (invalid_d || mag_q == '0) ? '0 : e_q[EXP_W-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            in_q      <= '0;
            mag_q     <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            err_q     <= 1'b0;
            fixed_q   <= '0;
            exp_q     <= '0;
            done_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            mag_q     <= mag_d;
            e_q       <= e_d;
            s_q       <= s_d;
            err_q     <= err_d;
            fixed_q   <= fixed_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.fixed_out = fixed_q;
    assign bus.exp_out   = exp_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.invalid   = invalid_q;
endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Multi-cycle IEEE-754 single-precision to scaled-integer converter; the inverse of the existing fixed-to-float converter.
- Produces a 32-bit two's-complement integer `fixed_out` and an 8-bit signed exponent `exp_out` such that value = fixed_out * 2^exp_out.
- `fixed_out` is minimal: odd, or zero.
- Trailing zeros are stripped one bit per clock. Sits on the return path so software and the bench can round-trip values.

Parameters:
- EXP_W, 8, width of exp_out (signed). Only 8 is verified.
- INT_W, 32, width of fixed_out (two's complement, >= 25).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- float_in  in  32  IEEE-754 single operand, sampled on an accepted load
- load_new  in  1  start request, sampled on the rising edge
- fixed_out  out  INT_W  integer result, registered
- exp_out  out  EXP_W  signed exponent result, registered
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when results update
- invalid  out  1  set with done for inf/NaN or exponent underflow; held until the next done

Behaviour:
- Reset: async on reset_n low.
  - state=IDLE; fixed_out=0, exp_out=0, busy=0, done=0, invalid=0.
  - Reset mid-conversion aborts it; nothing is written.
- busy = (state != IDLE). done is a registered pulse.
- Load accept: load_new=1 at an edge with state IDLE captures float_in; state -> UNPACK (edge E0).
  - load_new while busy is ignored; no queueing.
- UNPACK (edge E1). Internal variables: sign s, exponent field ef, fraction f; exponent held as a 10-bit signed e.
  - ef=255 (inf/NaN): state -> FINISH with err=1 (bypasses STRIP).
  - ef=0: mag=0, e=0 -> STRIP (no SUBNORMAL_EN only; see Optional Feature).
  - Otherwise: mag={1,f} (24 b), e=ef-127-23 -> STRIP.
- STRIP (one edge per step):
  - If mag==0 or mag[0]==1: -> FINISH.
  - Else mag>>=1, e+=1.
  - Number of shifts k <= 23.
- FINISH (one edge), then -> IDLE with done=1:
  - If err, or e < -(2^(EXP_W-1)): fixed_out=0, exp_out=0, invalid=1.
  - If mag==0: fixed_out=0, exp_out=0, invalid=0. Covers -0.0.
  - Otherwise: fixed_out = s ? -zext(mag) : zext(mag); exp_out = e[EXP_W-1:0]; invalid=0.
- Latency:
  - Normal/zero: done asserted after edge E3+k.
  - inf/NaN: done asserted after edge E2.
- e never exceeds +127 (max 127-23+23), so there is no overflow case.
- Outputs hold between done pulses.
- A load sampled on the edge after done (state IDLE) is accepted. Back-to-back operation has a one-cycle IDLE gap.

Optional Feature:
- Macro: FLOAT_TO_FIXED_SUBNORMAL_EN.
- Defined: ef=0 decodes as mag={0,f}, e=-149, then normal STRIP/FINISH.
  - f=0 still yields a zero result.
  - An underflow result (e < -128) raises invalid.
- Undefined: every ef=0 input flushes to fixed_out=0, exp_out=0, invalid=0.

Test Plan:
- 0x3F800000 -> fixed_out=0x00000001, exp_out=0x00, invalid=0; done exactly 26 cycles after the load edge (k=23); busy high throughout.
- 0x40D00000 (6.5) -> fixed_out=13, exp_out=0xFF; done after 23 cycles. Then 0xBF800000 -> fixed_out=0xFFFFFFFF, exp_out=0x00.
- Boundaries:
  - 0x4B000001 -> fixed_out=8388609, exp_out=0; done after 3 cycles (k=0).
  - 0x7F000000 -> fixed_out=1, exp_out=0x7F.
  - 0x80000000 -> 0 / 0, invalid=0.
- Invalid inputs:
  - 0x7F800000 -> invalid=1, fixed_out=0, exp_out=0; done after 2 cycles.
  - 0x00800001 -> e=-149, underflow -> invalid=1.
  - Next valid load (0x3F800000) clears invalid.
- Load/reset handling:
  - Pulse load_new with 0x40000000 while busy on 0x3F800000 -> ignored; result fixed_out=1, exp_out=0.
  - Drop reset_n mid-STRIP -> all outputs 0 immediately, no done.
  - After release, a new load completes normally.
- 0x00400000 with macro defined -> fixed_out=1, exp_out=0x81 (-127).
  - 0x00000001 with macro defined -> invalid=1.
  - Without macro, both inputs -> 0 / 0, invalid=0.
